regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single register-file write port (WE3/A3/WD3) between the core writeback path and an auxiliary requester, such as a debug/load-return unit. Core writeback has priority. Auxiliary writes are buffered in a 2-entry FIFO with a valid/ready handshake. A starvation counter forces a one-cycle core stall so auxiliary writes always drain. The block sits between the datapath writeback mux and the RegisterFile write port; read ports are untouched.

## Interface
- STARVE_LIMIT, 4: consecutive core-granted cycles with a pending aux write before the core is stalled; legal range 1..7.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- core_we  in  1  core writeback request.
- core_a3  in  5  core destination register.
- core_wd  in  32  core write data.
- stall  out  1  core request not accepted this cycle; core holds the request and repeats it next cycle.
- aux_valid  in  1  aux write offered.
- aux_ready  out  1  FIFO can accept; transfer occurs when aux_valid && aux_ready at a clock edge.
- aux_a3  in  5  aux destination register.
- aux_wd  in  32  aux write data.
- aux_pending  out  1  FIFO non-empty.
- rf_we3  out  1  to RegisterFile WE3.
- rf_a3  out  5  to RegisterFile A3.
- rf_wd3  out  32  to RegisterFile WD3.

## Operation
- FIFO states: EMPTY, ONE, TWO. FIFO state is stored as a count (0..2) plus head/tail pointers.
- aux_ready = !reset && (count != 2). It depends only on state, never on the same-cycle dequeue.
- Enqueue happens on aux_valid && aux_ready. An aux write with aux_a3 == 0 completes the handshake but is not stored.
- Grant priority each cycle, in order:
  - If stall is asserted, grant the FIFO head.
  - Else if core_we && core_a3 != 0, grant the core.
  - Else if the FIFO is non-empty, grant the FIFO head.
  - Else grant nothing.
- stall = !reset && core_we && aux_pending && (starve_cnt == STARVE_LIMIT).
- Write-port outputs:
  - Granted source drives rf_we3 = 1, rf_a3, rf_wd3.
  - No grant: rf_we3 = 0, rf_a3 = 0, rf_wd3 = 0.
- Core write to $0: rf_we3 stays 0 from the core. The port is free, so the FIFO head may be granted in the same cycle.
- starve_cnt (3 bits):
  - Resets to 0 on any FIFO grant, or when the FIFO is empty.
  - Increments (saturating at STARVE_LIMIT) when the core is granted while the FIFO is non-empty.
  - Otherwise holds.
- Transitions:
  - Enqueue only: count+1.
  - Dequeue only: count−1.
  - Both in ONE: count stays ONE, head advances.
  - TWO: no enqueue possible.
- Ordering: writes commit in grant order. There is no ordering guarantee between core and aux writes to the same register; the issuing software/controller resolves this using aux_pending.

## Timing
- Reset values (while reset is high and on the cycle after it drops):
  - count = 0, starve_cnt = 0, pointers = 0.
  - aux_ready = 0 while reset is high, 1 after.
  - stall = 0, aux_pending = 0, rf_we3 = 0.
- Reset mid-operation discards all buffered aux writes. No write-port activity occurs during reset cycles, even if core_we = 1.
- rf_* and stall are combinational from current state plus core_* inputs. The RegisterFile commits at the same rising edge.
- Core write latency is 0 cycles when not stalled. A stalled request is written exactly one cycle later, because the stall forces starve_cnt to 0 and only one FIFO entry drains per stall.
- Aux latency: accepted at edge N, earliest write-port cycle is N+1 (no bypass).
- Worst case for an aux entry at the head: written within STARVE_LIMIT+1 cycles.
- A simultaneous enqueue and dequeue in TWO cannot occur, since aux_ready = 0 there.

## Test plan
- Reset with core_we = 1, core_a3 = 5, aux_valid = 1 → rf_we3 = 0, aux_ready = 0, stall = 0; after reset, aux_pending = 0.
- Core only: core_we = 1, a3 = 5, wd = 0xDEADBEEF → same cycle rf_we3 = 1, rf_a3 = 5, rf_wd3 = 0xDEADBEEF, stall = 0. Read A1 = 5 afterwards returns 0xDEADBEEF.
- Aux idle-port path: aux a3 = 7, wd = 0x12345678, core idle → accepted at edge N, written at cycle N+1, aux_pending drops after that edge.
- FIFO full: three back-to-back aux offers (a3 = 1, 2, 3) while core_we = 1 continuously with STARVE_LIMIT = 4:
  - aux_ready = 0 after two accepts.
  - After 4 core grants, stall = 1 for one cycle and reg 1 is written.
  - Third offer is accepted next.
- $0 handling: core_we = 1, core_a3 = 0, with FIFO holding a3 = 9 → same cycle rf_we3 = 1, rf_a3 = 9. Aux write to $0 is acknowledged and never appears on the port.
- Reset asserted with two entries buffered → after reset, aux_pending = 0 and neither entry is ever written.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between core writeback (priority) and a
// 2-entry buffered auxiliary requester, with a starvation stall so aux writes drain.
module regfile_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_we,
    input  logic [4:0]  core_a3,
    input  logic [31:0] core_wd,
    output logic        stall,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_a3,
    input  logic [31:0] aux_wd,
    output logic        aux_pending,
    output logic        rf_we3,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd3
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fifo_state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    fifo_state_t count;
    logic        head;
    logic        tail;
    logic [4:0]  buf_a3 [2];
    logic [31:0] buf_wd [2];
    logic [2:0]  starve_cnt;

    logic core_real;
    logic core_grant;
    logic fifo_grant;
    logic enq;

    always_comb begin
        aux_ready   = !reset && (count != TWO);
        aux_pending = !reset && (count != EMPTY);
        core_real   = core_we && (core_a3 != 5'd0);
        stall       = !reset && core_we && aux_pending && (starve_cnt == LIMIT);
        // A core write to $0 leaves the port free, so the FIFO head may take it.
        fifo_grant  = aux_pending && (stall || !core_real);
        core_grant  = !reset && !stall && core_real;
        enq         = aux_valid && aux_ready && (aux_a3 != 5'd0);
    end

    always_comb begin
        rf_we3 = 1'b0;
        rf_a3  = '0;
        rf_wd3 = '0;
        if (fifo_grant) begin
            rf_we3 = 1'b1;
            rf_a3  = buf_a3[head];
            rf_wd3 = buf_wd[head];
        end else if (core_grant) begin
            rf_we3 = 1'b1;
            rf_a3  = core_a3;
            rf_wd3 = core_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= EMPTY;
            head       <= 1'b0;
            tail       <= 1'b0;
            starve_cnt <= '0;
        end else begin
            case ({enq, fifo_grant})
                2'b10:   count <= (count == EMPTY) ? ONE : TWO;
                2'b01:   count <= (count == TWO) ? ONE : EMPTY;
                default: count <= count;
            endcase
            if (enq)
                tail <= ~tail;
            if (fifo_grant)
                head <= ~head;

            if (fifo_grant || count == EMPTY)
                starve_cnt <= '0;
            else if (core_grant && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            buf_a3[tail] <= aux_a3;
            buf_wd[tail] <= aux_wd;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios then random traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        core_we;
    logic [4:0]  core_a3;
    logic [31:0] core_wd;
    logic        stall;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_a3;
    logic [31:0] aux_wd;
    logic        aux_pending;
    logic        rf_we3;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_we    (core_we),
        .core_a3    (core_a3),
        .core_wd    (core_wd),
        .stall      (stall),
        .aux_valid  (aux_valid),
        .aux_ready  (aux_ready),
        .aux_a3     (aux_a3),
        .aux_wd     (aux_wd),
        .aux_pending(aux_pending),
        .rf_we3     (rf_we3),
        .rf_a3      (rf_a3),
        .rf_wd3     (rf_wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
    } ent_t;

    ent_t q[$];
    int   starve;
    int   n_checks;
    int   n_pass;

    logic m_ready, m_pending, m_stall, m_we, m_fifo_wr, m_core_wr, m_accept;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic drive(input logic rst, input logic cwe, input logic [4:0] ca3,
                         input logic [31:0] cwd, input logic av, input logic [4:0] aa3,
                         input logic [31:0] awd);
        reset     = rst;
        core_we   = cwe;
        core_a3   = ca3;
        core_wd   = cwd;
        aux_valid = av;
        aux_a3    = aa3;
        aux_wd    = awd;
        #2;
    endtask

    // Reference: the head of the queue gets the port on stall or whenever the
    // core is not really writing; the core wins otherwise.
    task automatic compare_model();
        logic core_real;
        core_real = core_we && core_a3 != 5'd0;
        m_ready   = !reset && q.size() < 2;
        m_pending = !reset && q.size() > 0;
        m_stall   = m_pending && core_we && starve == LIMIT;
        m_fifo_wr = m_pending && (m_stall || !core_real);
        m_core_wr = !reset && !m_stall && core_real && !m_fifo_wr;
        m_accept  = aux_valid && m_ready;
        m_we = 1'b0; m_a3 = '0; m_wd = '0;
        if (m_fifo_wr) begin
            m_we = 1'b1; m_a3 = q[0].a3; m_wd = q[0].wd;
        end else if (m_core_wr) begin
            m_we = 1'b1; m_a3 = core_a3; m_wd = core_wd;
        end
        check("aux_ready",   32'(aux_ready),   32'(m_ready));
        check("aux_pending", 32'(aux_pending), 32'(m_pending));
        check("stall",       32'(stall),       32'(m_stall));
        check("rf_we3",      32'(rf_we3),      32'(m_we));
        check("rf_a3",       32'(rf_a3),       32'(m_a3));
        check("rf_wd3",      rf_wd3,           m_wd);
    endtask

    task automatic advance();
        ent_t e;
        if (reset) begin
            q.delete();
            starve = 0;
        end else begin
            if (m_fifo_wr || q.size() == 0)
                starve = 0;
            else if (m_core_wr && starve < LIMIT)
                starve++;
            if (m_fifo_wr)
                void'(q.pop_front());
            if (m_accept && aux_a3 != 5'd0) begin
                e.a3 = aux_a3;
                e.wd = aux_wd;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            compare_model();
            advance();
        end
    endtask

    logic        h_we;
    logic [4:0]  h_a3;
    logic [31:0] h_wd;
    int          k;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        starve   = 0;
        reset = 1'b1; core_we = 1'b0; core_a3 = '0; core_wd = '0;
        aux_valid = 1'b0; aux_a3 = '0; aux_wd = '0;
        @(posedge clk);
        #1;

        // Reset with activity on both requesters.
        drive(1'b1, 1'b1, 5'd5, 32'hAAAA_5555, 1'b1, 5'd6, 32'h1);
        check("rst_we3", 32'(rf_we3), 32'd0);
        check("rst_ready", 32'(aux_ready), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        compare_model();
        advance();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("post_rst_pending", 32'(aux_pending), 32'd0);
        check("post_rst_ready", 32'(aux_ready), 32'd1);
        compare_model();
        advance();

        // Core only.
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("core_we3", 32'(rf_we3), 32'd1);
        check("core_a3", 32'(rf_a3), 32'd5);
        check("core_wd", rf_wd3, 32'hDEADBEEF);
        check("core_stall", 32'(stall), 32'd0);
        compare_model();
        advance();

        // Aux through an idle port: no bypass, written the next cycle.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
        check("aux_nobypass", 32'(rf_we3), 32'd0);
        compare_model();
        advance();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("aux_we3", 32'(rf_we3), 32'd1);
        check("aux_a3", 32'(rf_a3), 32'd7);
        check("aux_wd", rf_wd3, 32'h12345678);
        compare_model();
        advance();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("aux_drained", 32'(aux_pending), 32'd0);
        compare_model();
        advance();

        // FIFO full under continuous core traffic, starvation stall drains reg 1.
        k = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b1, 5'd10, 32'h0A0A_0000 + 32'(c), k < 3, 5'(k + 1), 32'h100 + 32'(k));
            if (c == 2) check("full_ready", 32'(aux_ready), 32'd0);
            if (c == 5) begin
                check("starve_stall", 32'(stall), 32'd1);
                check("starve_a3", 32'(rf_a3), 32'd1);
            end
            if (c == 6) begin
                check("stall_one_cycle", 32'(stall), 32'd0);
                check("third_ready", 32'(aux_ready), 32'd1);
            end
            compare_model();
            if (m_accept) k++;
            advance();
        end
        idle(4);

        // $0 handling: core to $0 frees the port; aux to $0 is acked, not stored.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999);
        compare_model();
        advance();
        drive(1'b0, 1'b1, 5'd0, 32'h5A5A, 1'b1, 5'd0, 32'hBAD0);
        check("zero_we3", 32'(rf_we3), 32'd1);
        check("zero_a3", 32'(rf_a3), 32'd9);
        check("zero_aux_ready", 32'(aux_ready), 32'd1);
        compare_model();
        advance();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("zero_not_stored", 32'(aux_pending), 32'd0);
        check("zero_no_write", 32'(rf_we3), 32'd0);
        compare_model();
        advance();

        // Reset with two entries buffered discards them.
        drive(1'b0, 1'b1, 5'd11, 32'h11, 1'b1, 5'd20, 32'h20);
        compare_model();
        advance();
        drive(1'b0, 1'b1, 5'd11, 32'h11, 1'b1, 5'd21, 32'h21);
        compare_model();
        advance();
        drive(1'b1, 1'b1, 5'd11, 32'h11, 1'b0, 5'd0, 32'd0);
        check("midrst_we3", 32'(rf_we3), 32'd0);
        check("midrst_pending", 32'(aux_pending), 32'd0);
        compare_model();
        advance();
        idle(8);

        // Random traffic; a stalled core request is repeated unchanged.
        h_we = 1'b0; h_a3 = '0; h_wd = '0;
        m_stall = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!m_stall) begin
                h_we = ($urandom_range(9) < 6);
                h_a3 = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
                h_wd = $urandom;
            end
            drive(($urandom_range(199) == 0), h_we, h_a3, h_wd,
                  ($urandom_range(1) == 1),
                  ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom_range(31, 1)),
                  $urandom);
            compare_model();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
